// File: rtl/group_wb_collector_if.sv
// Handshake bundle for group_wb_collector.
//   grp_*  : register-group offer (base vreg + encoded LMUL), valid/ready
//   res_*  : micro-op results tagged with their index in the group, valid/ready
//   wr_*   : vregfile write port, en/ready
// slave  = the collector, master = whoever drives groups/results and the vregfile side.
interface group_wb_collector_if #(parameter int VLEN = 128);
  logic            grp_valid;
  logic            grp_ready;
  logic [4:0]      grp_rdest;
  logic [2:0]      grp_lmul;
  logic            res_valid;
  logic            res_ready;
  logic [2:0]      res_idx;
  logic [VLEN-1:0] res_data;
  logic            wr_en;
  logic            wr_ready;
  logic [4:0]      wr_addr;
  logic [VLEN-1:0] wr_data;

  modport slave (
    input  grp_valid, grp_rdest, grp_lmul, res_valid, res_idx, res_data, wr_ready,
    output grp_ready, res_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output grp_valid, grp_rdest, grp_lmul, res_valid, res_idx, res_data, wr_ready,
    input  grp_ready, res_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/group_wb_collector.sv
// group_wb_collector: accepts a vector register group (base vreg + LMUL), then
// collects LMUL in-order micro-op results and writes each one to the vregfile
// at base+idx (mod 32) through a single-entry output register.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : group/result/write handshakes (slave side)
//   flush      : abort the current group (highest priority)
//   grp_done   : 1-cycle pulse after the last register of a group is written
//   err        : 1-cycle pulse for illegal LMUL or out-of-order result index
//   busy       : collecting a group
module group_wb_collector #(parameter int VLEN = 128) (
  input  logic                  clk,
  input  logic                  rst_n,
  group_wb_collector_if.slave   bus,
  input  logic                  flush,
  output logic                  grp_done,
  output logic                  err,
  output logic                  busy
);
  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      total_q, total_d;
  logic [4:0]      base_q, base_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [VLEN-1:0] wr_data_q, wr_data_d;
  logic            last_q, last_d;
  logic            grp_done_q, grp_done_d;
  logic            err_q, err_d;

  logic accept, wr_fire;

  // Results stop being accepted once all LMUL indices have been taken, so a
  // trailing result can never be confused with the next group.
  assign bus.res_ready = rst_n && (state_q == COLLECT) && (cnt_q < total_q) &&
                         (!wr_en_q || bus.wr_ready);
  assign bus.grp_ready = rst_n && (state_q == IDLE);
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign grp_done      = grp_done_q;
  assign err           = err_q;
  assign busy          = (state_q == COLLECT);

  assign accept  = bus.res_valid && bus.res_ready;
  assign wr_fire = wr_en_q && bus.wr_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    total_d    = total_q;
    base_d     = base_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    last_d     = last_q;
    grp_done_d = 1'b0;
    err_d      = 1'b0;

    // Draining the output register; may be refilled below in the same cycle.
    if (wr_fire) wr_en_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.grp_valid) begin
          if (bus.grp_lmul[2]) begin
            err_d = 1'b1;
          end else begin
            base_d  = bus.grp_rdest;
            total_d = 4'd1 << bus.grp_lmul[1:0];
            cnt_d   = 4'd0;
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (wr_fire && last_q) begin
          grp_done_d = 1'b1;
          last_d     = 1'b0;
          state_d    = IDLE;
        end
        if (accept) begin
          if ({1'b0, bus.res_idx} == cnt_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + {1'b0, cnt_q};   // 5-bit wrap
            wr_data_d = bus.res_data;
            last_d    = (cnt_q == total_q - 4'd1);
            cnt_d     = cnt_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d    = IDLE;
      wr_en_d    = 1'b0;
      cnt_d      = 4'd0;
      last_d     = 1'b0;
      grp_done_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      total_q    <= '0;
      base_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      last_q     <= 1'b0;
      grp_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      total_q    <= total_d;
      base_q     <= base_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      last_q     <= last_d;
      grp_done_q <= grp_done_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_group_wb_collector.sv
module tb_group_wb_collector;
  localparam int VLEN = 128;
  localparam int OW   = 139;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic grp_done, err, busy;

  always #5 clk = ~clk;

  group_wb_collector_if #(.VLEN(VLEN)) bus ();

  group_wb_collector #(.VLEN(VLEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .grp_done(grp_done), .err(err), .busy(busy)
  );

  typedef struct {
    logic gv; logic [4:0] rd; logic [2:0] lm;
    logic rv; logic [2:0] ri; logic [31:0] rw;
    logic wrdy; logic fl;
    logic egr, erdy, ewe; logic [4:0] ewa; logic [31:0] ewd;
    logic edone, eerr, ebusy;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic gv, input logic [4:0] rd, input logic [2:0] lm,
                     input logic rv, input logic [2:0] ri, input logic [31:0] rw,
                     input logic wrdy, input logic fl,
                     input logic egr, input logic erdy, input logic ewe,
                     input logic [4:0] ewa, input logic [31:0] ewd,
                     input logic edone, input logic eerr, input logic ebusy);
    vec_t v;
    v.gv = gv; v.rd = rd; v.lm = lm; v.rv = rv; v.ri = ri; v.rw = rw;
    v.wrdy = wrdy; v.fl = fl; v.egr = egr; v.erdy = erdy; v.ewe = ewe;
    v.ewa = ewa; v.ewd = ewd; v.edone = edone; v.eerr = eerr; v.ebusy = ebusy;
    vq.push_back(v);
  endtask

  function automatic logic [OW-1:0] obs();
    return {bus.grp_ready, bus.res_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
            grp_done, err, busy};
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.grp_valid = 0; bus.grp_rdest = 0; bus.grp_lmul = 0;
    bus.res_valid = 0; bus.res_idx = 0; bus.res_data = '0;
    bus.wr_ready = 0; flush = 0;
  endtask

  initial begin
    logic [OW-1:0] g, e;
    logic [4:0] a;

    // A: base 8, LMUL 4, full throughput
    add(1,8,2, 0,0,0,     1,0, 1,0,0,0,0,        0,0,0);
    add(0,0,0, 1,0,'hA0,  1,0, 0,1,0,0,0,        0,0,1);
    add(0,0,0, 1,1,'hA1,  1,0, 0,1,1,8,'hA0,     0,0,1);
    add(0,0,0, 1,2,'hA2,  1,0, 0,1,1,9,'hA1,     0,0,1);
    add(0,0,0, 1,3,'hA3,  1,0, 0,1,1,10,'hA2,    0,0,1);
    add(0,0,0, 0,0,0,     1,0, 0,0,1,11,'hA3,    0,0,1);
    add(0,0,0, 0,0,0,     1,0, 1,0,0,0,0,        1,0,0);
    add(0,0,0, 0,0,0,     1,0, 1,0,0,0,0,        0,0,0);
    // B: base 30, LMUL 4, address wrap
    add(1,30,2, 0,0,0,    1,0, 1,0,0,0,0,        0,0,0);
    add(0,0,0, 1,0,'hB0,  1,0, 0,1,0,0,0,        0,0,1);
    add(0,0,0, 1,1,'hB1,  1,0, 0,1,1,30,'hB0,    0,0,1);
    add(0,0,0, 1,2,'hB2,  1,0, 0,1,1,31,'hB1,    0,0,1);
    add(0,0,0, 1,3,'hB3,  1,0, 0,1,1,0,'hB2,     0,0,1);
    add(0,0,0, 0,0,0,     1,0, 0,0,1,1,'hB3,     0,0,1);
    add(0,0,0, 0,0,0,     1,0, 1,0,0,0,0,        1,0,0);
    // C: base 5, LMUL 2, wr_ready low for 3 cycles on first write
    add(1,5,1, 0,0,0,     0,0, 1,0,0,0,0,        0,0,0);
    add(0,0,0, 1,0,'hC0,  0,0, 0,1,0,0,0,        0,0,1);
    add(0,0,0, 1,1,'hC1,  0,0, 0,0,1,5,'hC0,     0,0,1);
    add(0,0,0, 1,1,'hC1,  0,0, 0,0,1,5,'hC0,     0,0,1);
    add(0,0,0, 1,1,'hC1,  0,0, 0,0,1,5,'hC0,     0,0,1);
    add(0,0,0, 1,1,'hC1,  1,0, 0,1,1,5,'hC0,     0,0,1);
    add(0,0,0, 0,0,0,     1,0, 0,0,1,6,'hC1,     0,0,1);
    add(0,0,0, 0,0,0,     1,0, 1,0,0,0,0,        1,0,0);
    // D: illegal LMUL, then out-of-order index, then recovery
    add(1,0,5, 0,0,0,     1,0, 1,0,0,0,0,        0,0,0);
    add(0,0,0, 0,0,0,     1,0, 1,0,0,0,0,        0,1,0);
    add(0,0,0, 0,0,0,     1,0, 1,0,0,0,0,        0,0,0);
    add(1,12,1, 0,0,0,    1,0, 1,0,0,0,0,        0,0,0);
    add(0,0,0, 1,1,'hD9,  1,0, 0,1,0,0,0,        0,0,1);
    add(0,0,0, 0,0,0,     1,0, 0,1,0,0,0,        0,1,1);
    add(0,0,0, 1,0,'hD0,  1,0, 0,1,0,0,0,        0,0,1);
    add(0,0,0, 1,1,'hD1,  1,0, 0,1,1,12,'hD0,    0,0,1);
    add(0,0,0, 0,0,0,     1,0, 0,0,1,13,'hD1,    0,0,1);
    add(0,0,0, 0,0,0,     1,0, 1,0,0,0,0,        1,0,0);
    // E: LMUL 8 flushed after 3 writes, then a fresh group starts at cnt 0
    add(1,16,3, 0,0,0,    1,0, 1,0,0,0,0,        0,0,0);
    add(0,0,0, 1,0,'hE0,  1,0, 0,1,0,0,0,        0,0,1);
    add(0,0,0, 1,1,'hE1,  1,0, 0,1,1,16,'hE0,    0,0,1);
    add(0,0,0, 1,2,'hE2,  1,0, 0,1,1,17,'hE1,    0,0,1);
    add(0,0,0, 1,3,'hE3,  1,0, 0,1,1,18,'hE2,    0,0,1);
    add(0,0,0, 0,0,0,     0,1, 0,0,1,19,'hE3,    0,0,1);
    add(0,0,0, 0,0,0,     1,0, 1,0,0,0,0,        0,0,0);
    add(1,2,0, 0,0,0,     1,0, 1,0,0,0,0,        0,0,0);
    add(0,0,0, 1,0,'hF0,  1,0, 0,1,0,0,0,        0,0,1);
    add(0,0,0, 0,0,0,     1,0, 0,0,1,2,'hF0,     0,0,1);
    add(0,0,0, 0,0,0,     1,0, 1,0,0,0,0,        1,0,0);

    // Reset state
    rst_n = 0; idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outputs", obs(), '0);
    rst_n = 1;
    #1;
    chk("grp_ready_after_reset", {{(OW-2){1'b0}}, bus.grp_ready, busy}, {{(OW-2){1'b0}}, 2'b10});

    // Table-driven vectors: drive at negedge, sample 1 time unit later
    foreach (vq[i]) begin
      @(negedge clk);
      bus.grp_valid = vq[i].gv; bus.grp_rdest = vq[i].rd; bus.grp_lmul = vq[i].lm;
      bus.res_valid = vq[i].rv; bus.res_idx = vq[i].ri; bus.res_data = {4{vq[i].rw}};
      bus.wr_ready = vq[i].wrdy; flush = vq[i].fl;
      #1;
      g = obs();
      if (!vq[i].ewe) g[VLEN+7:3] = '0;  // addr/data are don't-care without wr_en
      e = {vq[i].egr, vq[i].erdy, vq[i].ewe, vq[i].ewa, {4{vq[i].ewd}},
           vq[i].edone, vq[i].eerr, vq[i].ebusy};
      chk($sformatf("vec%0d", i), g, e);
    end

    // LMUL 8 at full throughput from base 28: eight back-to-back writes, wrapping
    @(negedge clk); idle_inputs();
    bus.grp_valid = 1; bus.grp_rdest = 28; bus.grp_lmul = 3; bus.wr_ready = 1;
    @(negedge clk); bus.grp_valid = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      bus.res_valid = (k < 8); bus.res_idx = 3'(k); bus.res_data = {4{32'hC8 + 32'(k)}};
      #1;
      if (k == 0)
        chk("l8_first", {bus.wr_en, grp_done}, 2'b00);
      else if (k <= 8) begin
        a = 5'(28 + k - 1);
        chk($sformatf("l8_w%0d", k), {bus.wr_en, grp_done, bus.wr_addr, bus.wr_data},
            {1'b1, 1'b0, a, {4{32'hC8 + 32'(k - 1)}}});
      end else
        chk("l8_done", {bus.wr_en, grp_done, busy}, 3'b010);
    end

    // Reset mid-group with a pending write
    @(negedge clk); idle_inputs();
    bus.grp_valid = 1; bus.grp_rdest = 20; bus.grp_lmul = 3;
    @(negedge clk); bus.grp_valid = 0;
    bus.res_valid = 1; bus.res_idx = 0; bus.res_data = {4{32'h5A5A5A5A}};
    @(negedge clk); bus.res_valid = 0;
    #1;
    chk("pending_write", {bus.wr_en, bus.wr_addr}, {1'b1, 5'd20});
    rst_n = 0;
    @(negedge clk); #1;
    chk("midgroup_reset", obs(), '0);
    rst_n = 1;
    @(negedge clk); #1;
    chk("post_reset_idle", {bus.grp_ready, bus.res_ready, bus.wr_en, grp_done, err, busy},
        6'b100000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/group_wb_collector.md
GROUP_WB_COLLECTOR -- requirements
Module: group_wb_collector

Interface
REQ-001 Parameter VLEN, default 128, meaning width in bits of one vector register (one micro-op result).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 grp_valid  input  1  new register group offered for collection.
REQ-005 grp_ready  output  1  block can accept a group.
REQ-006 grp_rdest  input  5  base destination vreg of group.
REQ-007 grp_lmul  input  3  encoded LMUL: 0->1, 1->2, 2->4, 3->8 registers; 4..7 illegal.
REQ-008 res_valid  input  1  micro-op result valid.
REQ-009 res_ready  output  1  block accepts result this cycle.
REQ-010 res_idx  input  3  micro-op index within group (0..LMUL-1), as issued by the grouping counter.
REQ-011 res_data  input  VLEN  micro-op result.
REQ-012 wr_en  output  1  vregfile write request.
REQ-013 wr_ready  input  1  vregfile accepts write this cycle.
REQ-014 wr_addr  output  5  vreg written.
REQ-015 wr_data  output  VLEN  data written.
REQ-016 flush  input  1  abort current group.
REQ-017 grp_done  output  1  one-cycle pulse: final register of group written.
REQ-018 err  output  1  one-cycle pulse: illegal LMUL or out-of-order res_idx.
REQ-019 busy  output  1  high in COLLECT state.

Function
REQ-020 FSM states SHALL be IDLE and COLLECT; grp_ready = (state==IDLE) && rst_n; busy = (state==COLLECT).
REQ-021 IDLE: grp_valid && legal grp_lmul -> latch base=grp_rdest, total=decoded LMUL, cnt=0, go COLLECT next edge.
REQ-022 IDLE: grp_valid && grp_lmul>=4 -> err=1 next cycle, no latch, remain IDLE.
REQ-023 res_ready SHALL be 1 only in COLLECT when output write register is empty or wr_ready=1 (single-entry pipeline, no bubble under full throughput).
REQ-024 Result accepted (res_valid&&res_ready) with res_idx==cnt -> load output register: wr_en=1, wr_addr=(base+cnt) mod 32, wr_data=res_data, last flag=(cnt==total-1); cnt increments.
REQ-025 Accepted result with res_idx!=cnt -> err pulse next cycle, result dropped, cnt and write register unchanged.
REQ-026 wr_en, wr_addr, wr_data SHALL hold stable while wr_en=1 and wr_ready=0.
REQ-027 wr_en&&wr_ready with last flag -> grp_done=1 for exactly one cycle (next cycle), state returns to IDLE same edge; further results not accepted.
REQ-028 Latency: result accepted at edge N appears on wr_* from cycle N+1; with wr_ready held 1, LMUL=8 group completes in 8 consecutive write cycles.
REQ-029 Address arithmetic 5-bit, wraps 31->0 (base 30, LMUL 4 -> 30,31,0,1).
REQ-030 flush SHALL take priority over all events: next edge clears wr_en, cnt, last flag, state->IDLE; no grp_done, no err.
REQ-031 grp_valid in COLLECT SHALL be ignored (grp_ready=0); err and grp_done never asserted in same cycle.

Reset
REQ-032 While rst_n=0 at an edge: state=IDLE, cnt=0, base=0, total=0, wr_en=0, wr_addr=0, wr_data=0, grp_done=0, err=0; reset mid-group discards group and pending write.
REQ-033 grp_ready and res_ready SHALL be 0 while rst_n=0.

Verification
REQ-034 grp_rdest=8, grp_lmul=2, four in-order results, wr_ready=1 -> writes to 8,9,10,11 on consecutive cycles, grp_done one cycle after the write to 11.
REQ-035 grp_rdest=30, grp_lmul=2 -> wr_addr sequence 30,31,0,1.
REQ-036 LMUL=2, wr_ready=0 for 3 cycles on first write -> wr_addr=base, wr_data held, res_ready=0, second result stalls, completes after release.
REQ-037 grp_lmul=5 -> err pulse, grp_ready stays 1, no wr_en; LMUL=2 with res_idx=1 first -> err pulse, no write.
REQ-038 flush during LMUL=8 after 3 writes -> next cycle IDLE, wr_en=0, no grp_done; new group accepted with cnt=0.
REQ-039 rst_n=0 mid-group with pending write -> all outputs 0, then grp_ready=1 after release.
